regfile_sb: RTL and testbench

Parametrised multi-read-port register file for the RV32I core, with an integrated issue scoreboard and a post-reset clearing sweep. Storage has no reset, so it can map onto distributed RAM. A small state machine zeroes every register after reset. Per-register pending bits tell decode which source operands are still awaiting writeback. It replaces the fixed 32x32 register file and sits between decode/issue (read, issue) and writeback (write).

---
 rtl/rv_pkg.sv | 14 +
 rtl/regfile_sb_score.sv | 64 ++++++
 rtl/regfile_sb.sv | 143 ++++++++++++++
 tb/tb_regfile_sb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: register-file defaults, the sweep FSM state enum
// and the zero-register address.
package rv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int REG_ZERO = 0;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_sb_score.sv
// Issue scoreboard: one pending bit per architectural register, set on issue,
// cleared on writeback, looked up for the two read ports.
module regfile_sb_score
    import rv_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic          busy_a,
    output logic          busy_b
);

    // Register 0 never becomes pending, so it has no storage bit.
    logic [NREG-1:REG_ZERO+1] pend_r;
    logic [NREG-1:REG_ZERO+1] pend_nx_s;
    logic                     busy_a_s;
    logic                     busy_b_s;

    // Per-bit next state; issue wins over a same-cycle writeback to the same register.
    always_comb begin
        pend_nx_s = pend_r;
        for (int i = REG_ZERO + 1; i < NREG; i++) begin
            if (run && iss_valid && (iss_rd == AW'(i))) begin
                pend_nx_s[i] = 1'b1;
            end else if (run && we && (waddr == AW'(i))) begin
                pend_nx_s[i] = 1'b0;
            end else begin
                pend_nx_s[i] = pend_r[i];
            end
        end
    end

    // Pending-bit array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r <= '0;
        end else begin
            pend_r <= pend_nx_s;
        end
    end

    // Busy lookups; addresses 0 and out-of-range match no entry and read as 0.
    always_comb begin
        busy_a_s = 1'b0;
        busy_b_s = 1'b0;
        for (int i = REG_ZERO + 1; i < NREG; i++) begin
            busy_a_s = (raddr_a == AW'(i)) ? pend_r[i] : busy_a_s;
            busy_b_s = (raddr_b == AW'(i)) ? pend_r[i] : busy_b_s;
        end
    end

    assign busy_a = run & busy_a_s;
    assign busy_b = run & busy_b_s;

endmodule

// File: rtl/regfile_sb.sv
// Two-read-port register file with post-reset clearing sweep and issue scoreboard.
// Optional REGFILE_BYPASS_EN: same-cycle write-through forwarding to the read ports.
module regfile_sb
    import rv_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ready,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_b,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            busy_a,
    output logic            busy_b
);

`ifdef REGFILE_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    rf_state_e       state_r;
    rf_state_e       state_nx_s;
    logic [AW-1:0]   ptr_r;
    logic [AW-1:0]   ptr_nx_s;
    logic            run_s;

    // Unreset storage so it can map onto distributed RAM; x0 has no entry.
    logic [XLEN-1:0] mem_r [REG_ZERO+1:NREG-1];
    logic            mem_we_s;
    logic [AW-1:0]   mem_waddr_s;
    logic [XLEN-1:0] mem_wdata_s;

    logic            byp_a_s;
    logic            byp_b_s;
    logic [XLEN-1:0] rd_a_s;
    logic [XLEN-1:0] rd_b_s;

    assign run_s = (state_r == RUN);
    assign ready = run_s;

    // Sweep FSM and pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= CLEAR;
            ptr_r   <= AW'(REG_ZERO + 1);
        end else begin
            state_r <= state_nx_s;
            ptr_r   <= ptr_nx_s;
        end
    end

    // Sweep next state: walk the pointer up to the last register, then run forever.
    always_comb begin
        state_nx_s = state_r;
        ptr_nx_s   = ptr_r;
        case (state_r)
            CLEAR: begin
                if (ptr_r == AW'(NREG - 1)) begin
                    state_nx_s = RUN;
                end else begin
                    ptr_nx_s = ptr_r + AW'(1);
                end
            end
            RUN: begin
                state_nx_s = RUN;
            end
            default: begin
                state_nx_s = CLEAR;
            end
        endcase
    end

    // Storage write port: the sweep owns it during CLEAR, writeback owns it in RUN.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = '0;
        if (state_r == CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = ptr_r;
            mem_wdata_s = '0;
        end else if (we) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = waddr;
            mem_wdata_s = wdata;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Storage array; writes to x0 or beyond NREG match no entry and are dropped.
    always_ff @(posedge clk) begin
        for (int i = REG_ZERO + 1; i < NREG; i++) begin
            if (mem_we_s && (mem_waddr_s == AW'(i))) begin
                mem_r[i] <= mem_wdata_s;
            end
        end
    end

    assign byp_a_s = BYPASS & run_s & we & (waddr == raddr_a);
    assign byp_b_s = BYPASS & run_s & we & (waddr == raddr_b);

    // Read muxes; x0 and out-of-range addresses fall through to zero.
    always_comb begin
        rd_a_s = '0;
        rd_b_s = '0;
        for (int i = REG_ZERO + 1; i < NREG; i++) begin
            rd_a_s = (raddr_a == AW'(i)) ? (byp_a_s ? wdata : mem_r[i]) : rd_a_s;
            rd_b_s = (raddr_b == AW'(i)) ? (byp_b_s ? wdata : mem_r[i]) : rd_b_s;
        end
    end

    assign rdata_a = run_s ? rd_a_s : '0;
    assign rdata_b = run_s ? rd_b_s : '0;

    regfile_sb_score #(
        .NREG (NREG)
    ) u_score (
        .clk       (clk),
        .rst       (rst),
        .run       (run_s),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .we        (we),
        .waddr     (waddr),
        .raddr_a   (raddr_a),
        .raddr_b   (raddr_b),
        .busy_a    (busy_a),
        .busy_b    (busy_b)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            ready;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [AW-1:0]   raddr_a;
    logic [XLEN-1:0] rdata_a;
    logic [AW-1:0]   raddr_b;
    logic [XLEN-1:0] rdata_b;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            busy_a;
    logic            busy_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural values, pending flags, edges since reset release.
    logic [XLEN-1:0] m_mem [NREG];
    bit              m_pend [NREG];
    int              m_edges;

    regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr_a   (raddr_a),
        .rdata_a   (rdata_a),
        .raddr_b   (raddr_b),
        .rdata_b   (rdata_b),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy_a    (busy_a),
        .busy_b    (busy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return (m_edges >= NREG - 1);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
        if (!m_ready() || a == 0) return 32'h0;
        if (BYP && we && waddr == a) return wdata;
        return m_mem[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [AW-1:0] a);
        if (!m_ready()) return 32'h0;
        return {31'h0, m_pend[a]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_mem[i]  = 32'h0;
            m_pend[i] = 1'b0;
        end
        m_edges = 0;
    endtask

    task automatic idle_inputs();
        we = 1'b0; waddr = '0; wdata = '0; iss_valid = 1'b0; iss_rd = '0;
    endtask

    task automatic check_all();
        #1;
        chk("ready",   {31'h0, ready},  {31'h0, m_ready()});
        chk("rdata_a", rdata_a,         exp_rd(raddr_a));
        chk("rdata_b", rdata_b,         exp_rd(raddr_b));
        chk("busy_a",  {31'h0, busy_a}, exp_busy(raddr_a));
        chk("busy_b",  {31'h0, busy_b}, exp_busy(raddr_b));
    endtask

    // One rising edge; the model applies the rules to the inputs present at it.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            if (m_ready()) begin
                if (we && waddr != 0) m_mem[waddr] = wdata;
                if (we) m_pend[waddr] = 1'b0;
                if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
            end
            if (m_edges < 1000) m_edges++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        check_all();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Runs the sweep, optionally hammering x3 with writes/issues, and checks its length.
    task automatic sweep(input string tag, input bit junk);
        int seen = -1;
        for (int e = 0; e < NREG + 8; e++) begin
            if (junk && !m_ready()) begin
                we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF_FFFF;
                iss_valid = 1'b1; iss_rd = 5'd3;
            end else begin
                idle_inputs();
            end
            raddr_a = AW'($urandom_range(0, NREG - 1));
            raddr_b = AW'($urandom_range(0, NREG - 1));
            check_all();
            if (ready === 1'b1) begin
                seen = e;
                break;
            end
            tick();
        end
        chk(tag, seen, NREG - 1);
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        raddr_a = '0;
        raddr_b = '0;
        model_reset();
        @(negedge clk);

        // Reset release, sweep length, and all-zero contents afterwards.
        do_reset();
        sweep("clear_latency", 1'b0);
        for (int i = 0; i < NREG; i++) begin
            raddr_a = AW'(i);
            raddr_b = AW'(NREG - 1 - i);
            check_all();
        end

        // Write x5 and read it on both ports.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        raddr_a = 5'd5; raddr_b = 5'd5;
        check_all();
        if (BYP) chk("x5_bypass", rdata_a, 32'hDEAD_BEEF);
        tick();
        idle_inputs();
        check_all();
        chk("x5_a", rdata_a, 32'hDEAD_BEEF);
        chk("x5_b", rdata_b, 32'hDEAD_BEEF);

        // Write to x0 is discarded and never forwarded.
        we = 1'b1; waddr = 5'd0; wdata = 32'h0000_1234;
        raddr_a = 5'd0; raddr_b = 5'd0;
        check_all();
        chk("x0_same", rdata_b, 32'h0);
        tick();
        idle_inputs();
        check_all();
        chk("x0_next", rdata_a, 32'h0);

        // Scoreboard: issue, writeback, then set-beats-clear.
        iss_valid = 1'b1; iss_rd = 5'd7; raddr_a = 5'd7; raddr_b = 5'd7;
        check_all();
        tick();
        idle_inputs();
        check_all();
        chk("busy_issue", {31'h0, busy_a}, 32'h1);
        we = 1'b1; waddr = 5'd7; wdata = 32'h0000_0077;
        tick();
        idle_inputs();
        check_all();
        chk("busy_wb", {31'h0, busy_a}, 32'h0);
        iss_valid = 1'b1; iss_rd = 5'd7; we = 1'b1; waddr = 5'd7; wdata = 32'h0000_0777;
        tick();
        idle_inputs();
        check_all();
        chk("busy_set_wins", {31'h0, busy_a}, 32'h1);

        // Randomized traffic, mostly on a small address window to force collisions.
        for (int c = 0; c < 600; c++) begin
            bit narrow = ($urandom_range(0, 3) != 0);
            int amax   = narrow ? 7 : NREG - 1;
            we        = 1'($urandom_range(0, 1));
            waddr     = AW'($urandom_range(0, amax));
            wdata     = $urandom;
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = AW'($urandom_range(0, amax));
            raddr_a   = AW'($urandom_range(0, amax));
            raddr_b   = AW'($urandom_range(0, amax));
            check_all();
            tick();
        end

        // Mid-run reset drops ready and busy immediately.
        idle_inputs();
        iss_valid = 1'b1; iss_rd = 5'd9; raddr_a = 5'd9; raddr_b = 5'd7;
        tick();
        idle_inputs();
        check_all();
        rst = 1'b0;
        #1;
        chk("rst_run_ready", {31'h0, ready},  32'h0);
        chk("rst_run_busy",  {31'h0, busy_a}, 32'h0);
        chk("rst_run_rdata", rdata_b,         32'h0);
        do_reset();

        // Reset at edge 10 of the sweep, with junk writes/issues to x3 during CLEAR.
        for (int e = 0; e < 10; e++) begin
            we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF_FFFF;
            iss_valid = 1'b1; iss_rd = 5'd3;
            check_all();
            tick();
        end
        rst = 1'b0;
        #1;
        chk("rst_sweep_ready", {31'h0, ready}, 32'h0);
        idle_inputs();
        do_reset();
        sweep("clear_restart", 1'b1);
        raddr_a = 5'd3; raddr_b = 5'd9;
        check_all();
        chk("x3_clear_data", rdata_a,         32'h0);
        chk("x3_clear_busy", {31'h0, busy_a}, 32'h0);
        chk("x9_pend_reset", {31'h0, busy_b}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
